// File: rtl/digit_pipe_pkg.sv
// Shared constants for the digit pipeline register slice and the
// occupancy-counter width helper.
package digit_pipe_pkg;

  localparam int DIGIT_W     = 7;
  localparam int DIGIT_DEPTH = 4;

  // Bits needed to count 0..depth held digits
  function automatic int occ_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/digit_pipe_stage.sv
// One stage of the digit pipeline: a valid flag and a data register.
// Flush clears validity only; the data register keeps its contents.
module digit_pipe_stage
  import digit_pipe_pkg::*;
#(
  parameter int WIDTH = DIGIT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             i_load,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage state: data only moves when a valid digit arrives from upstream
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= i_up_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/digit_pipe_reg.sv
// Elastic DEPTH-stage pipeline register for systolic-multiplier digits with
// bubble collapse. Define DIGIT_PIPE_OCC_EN to add the registered occ output.
module digit_pipe_reg
  import digit_pipe_pkg::*;
#(
  parameter int WIDTH = DIGIT_W,
  parameter int DEPTH = DIGIT_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef DIGIT_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d    [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_up_v;
  logic [WIDTH-1:0] w_up_d [DEPTH];
  logic             w_accept;

  // Stage i can load when the sink takes the head or any stage from i onward is empty
  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i] = out_ready | ~(&(w_v | ((DEPTH'(1'b1) << i) - DEPTH'(1'b1))));
    end
  end

  assign in_ready = w_rdy[0] & ~flush;
  assign w_accept = in_valid & in_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_up_v[g] = w_accept;
      assign w_up_d[g] = in_data;
    end else begin : g_body
      assign w_up_v[g] = w_v[g-1];
      assign w_up_d[g] = w_d[g-1];
    end

    digit_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .i_load    (w_rdy[g]),
      .i_up_valid(w_up_v[g]),
      .i_up_data (w_up_d[g]),
      .o_valid   (w_v[g]),
      .o_data    (w_d[g])
    );
  end

  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

`ifdef DIGIT_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             w_emit;

  assign w_emit = out_valid & out_ready;

  // Occupancy follows accepts minus emits; flush empties every stage at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_emit})
        2'b10:   r_occ <= r_occ + OCC_W'(1'b1);
        2'b01:   r_occ <= r_occ - OCC_W'(1'b1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ = r_occ;
`endif

endmodule

// File: tb/tb_digit_pipe_reg.sv
// Self-checking bench for digit_pipe_reg (WIDTH=7, DEPTH=4): vector table,
// directed corner sequences and a randomized run against a positional model.
module tb_digit_pipe_reg;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] out_data;
  logic       out_ready;
`ifdef DIGIT_PIPE_OCC_EN
  logic [2:0] occ;
`endif

  int total = 0;
  int bad   = 0;

  // Model: every held digit in acceptance order with its stage position
  int         q_pos[$];
  logic [6:0] q_dat[$];

  typedef struct {
    logic       iv;
    logic [6:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [6:0] e_od;
  } vec_t;

  vec_t tbl[10];

  digit_pipe_reg #(.WIDTH(7), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef DIGIT_PIPE_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic m_ir();
    return !flush && ((q_pos.size() < DEPTH) || out_ready);
  endfunction

  function automatic logic m_ov();
    return (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
  endfunction

  task automatic model_clear();
    q_pos.delete();
    q_dat.delete();
  endtask

  // Digits advance oldest-first into the next free position; position DEPTH means emitted
  task automatic model_edge();
    logic acc;
    int   limit;
    acc = in_valid && m_ir();
    if (flush) begin
      model_clear();
    end else begin
      limit = out_ready ? DEPTH + 1 : DEPTH;
      foreach (q_pos[k]) begin
        if (q_pos[k] + 1 < limit) q_pos[k] = q_pos[k] + 1;
        limit = q_pos[k];
      end
      if (q_pos.size() > 0 && q_pos[0] == DEPTH) begin
        void'(q_pos.pop_front());
        void'(q_dat.pop_front());
      end
      if (acc) begin
        q_pos.push_back(0);
        q_dat.push_back(in_data);
      end
    end
  endtask

  task automatic mcheck(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_ir()));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov()));
    if (m_ov()) chk({tag, "_out_data"}, 32'(out_data), 32'(q_dat[0]));
`ifdef DIGIT_PIPE_OCC_EN
    chk({tag, "_occ"}, 32'(occ), 32'(q_pos.size()));
`endif
  endtask

  task automatic drive(input logic iv, input logic [6:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 7'h11, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[1] = '{1'b1, 7'h22, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[2] = '{1'b1, 7'h33, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[3] = '{1'b1, 7'h44, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[4] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h11};
    tbl[5] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'h11};
    tbl[6] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'h22};
    tbl[7] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'h33};
    tbl[8] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'h44};
    tbl[9] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00};

    // Reset held with a digit offered
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 7'h55; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_out_data", 32'(out_data), 32'(7'h00));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
`ifdef DIGIT_PIPE_OCC_EN
    chk("rst_occ", 32'(occ), 32'(3'd0));
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1'b1));
    tick();

    // Backpressure table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      mcheck($sformatf("tbl%0d_m", i));
      tick();
    end

    // Streaming 01..0A: first digit DEPTH edges after its accept, no gaps
    for (int k = 0; k < 16; k++) begin
      drive(k < 10, 7'(k + 1), 1'b1, 1'b0);
      chk($sformatf("strm%0d_out_valid", k), 32'(out_valid), 32'(k >= DEPTH && k < DEPTH + 10));
      if (k >= DEPTH && k < DEPTH + 10)
        chk($sformatf("strm%0d_out_data", k), 32'(out_data), 32'(k - DEPTH + 1));
      tick();
    end

    // Bubble collapse under a stalled sink
    drive(1'b1, 7'h12, 1'b0, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 7'h34, 1'b0, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b1, 1'b0);
    chk("bub_out_valid0", 32'(out_valid), 32'(1'b1));
    chk("bub_out_data0", 32'(out_data), 32'(7'h12));
`ifdef DIGIT_PIPE_OCC_EN
    chk("bub_occ", 32'(occ), 32'(3'd2));
`endif
    tick();
    drive(1'b0, 7'h00, 1'b1, 1'b0);
    chk("bub_out_valid1", 32'(out_valid), 32'(1'b1));
    chk("bub_out_data1", 32'(out_data), 32'(7'h34));
    tick();
    drive(1'b0, 7'h00, 1'b1, 1'b0);
    chk("bub_out_valid2", 32'(out_valid), 32'(1'b0));
    tick();

    // Flush with a simultaneous offer of 7F
    drive(1'b1, 7'h21, 1'b0, 1'b0); tick();
    drive(1'b1, 7'h43, 1'b0, 1'b0); tick();
    drive(1'b1, 7'h65, 1'b0, 1'b0); tick();
    drive(1'b1, 7'h7F, 1'b0, 1'b1);
    chk("fl_in_ready", 32'(in_ready), 32'(1'b0));
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 7'h00, 1'b1, 1'b0);
      chk($sformatf("fl%0d_out_valid", k), 32'(out_valid), 32'(1'b0));
`ifdef DIGIT_PIPE_OCC_EN
      chk($sformatf("fl%0d_occ", k), 32'(occ), 32'(3'd0));
`endif
      tick();
    end

    // Mid-stream reset pulse
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 7'(8'h40 + k), 1'b1, 1'b0);
      mcheck($sformatf("mr%0d", k));
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'(1'b0));
    chk("mr_out_data", 32'(out_data), 32'(7'h00));
    chk("mr_in_ready", 32'(in_ready), 32'(1'b1));
`ifdef DIGIT_PIPE_OCC_EN
    chk("mr_occ", 32'(occ), 32'(3'd0));
`endif
    model_clear();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(k == 2, 7'h5A, 1'b1, 1'b0);
      mcheck($sformatf("mrpost%0d", k));
      tick();
    end

    // Randomized traffic with occasional flush, against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 7'($urandom()),
            $urandom_range(0, 99) < ((k < 200) ? 80 : 30),
            $urandom_range(0, 29) == 0);
      mcheck($sformatf("rnd%0d", k));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_pipe_reg.md
DIGIT_PIPE_REG -- requirements
Module: digit_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 7: data width in bits per stage (digit width of the systolic multiplier), minimum 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all held data.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream digit.
REQ-008 SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: the last stage holds a valid digit.
REQ-010 SHALL have port out_data, output, WIDTH bits: the last-stage digit, driven directly from a register.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.

Function
REQ-012 SHALL number stages 0 (input side) to DEPTH-1 (output side); each stage holds a valid bit v[i] and a data register d[i].
REQ-013 SHALL compute stage ready r[i] = !v[i] | r[i+1], with r[DEPTH] = out_ready; in_ready = r[0] & !flush.
REQ-014 SHALL, when r[i]=1, load v[i] from the upstream valid (in_valid & in_ready for stage 0), and load d[i] only when that upstream valid is 1; otherwise d[i] holds.
REQ-015 SHALL hold v[i] and d[i] when r[i]=0 (stall); no accepted digit is lost or duplicated.
REQ-016 SHALL give latency DEPTH cycles: a digit accepted at edge N into an empty pipe with out_ready=1 is presented on out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH edges including the accept.
REQ-017 SHALL sustain throughput of one digit per cycle while out_ready=1.
REQ-018 SHALL collapse bubbles: an empty stage accepts from upstream even when downstream is stalled.
REQ-019 SHALL keep digits in acceptance order (FIFO order).
REQ-020 SHALL, on flush=1, clear every v[i] at the next edge, force in_ready=0, and drop in_valid for that cycle; d[i] are not required to change.
REQ-021 SHALL give flush priority over a simultaneous in_valid, out_ready or stall.
REQ-022 SHALL keep out_valid/out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-023 SHALL, on rstn=0, immediately clear all v[i] and d[i] to 0: out_valid=0, out_data=0, in_ready=1 (if flush=0).
REQ-024 SHALL discard all in-flight digits when reset is asserted mid-operation; the first accept after release follows REQ-016.

Configuration
REQ-025 SHALL, with macro DIGIT_PIPE_OCC_EN defined, add output port occ, width $clog2(DEPTH+1), equal to the count of set v[i] (0..DEPTH), registered, reset 0, 0 after flush, incremented/decremented per accept/emit.
REQ-026 SHALL, without DIGIT_PIPE_OCC_EN, have no occ port and no counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL take default constants DIGIT_W=7 and DIGIT_DEPTH=4 from the shared package digit_pipe_pkg; the package also holds the occupancy-width helper function.
REQ-028 SHALL instantiate DEPTH copies of sub-module digit_pipe_stage (one v/d pair with async active-low reset) in a generate loop; ready chain and counter live in the top level.

Verification (WIDTH=7, DEPTH=4)
REQ-029 Reset: hold rstn=0 with in_valid=1, in_data=7'h55 -> out_valid=0, out_data=7'h00, occ=0; after release in_ready=1.
REQ-030 Streaming: out_ready=1, feed 7'h01..7'h0A on consecutive cycles -> out emits 7'h01..7'h0A in order, first one DEPTH edges after its accept, no gaps.
REQ-031 Backpressure: fill with 7'h11,7'h22,7'h33,7'h44, out_ready=0 -> in_ready=0, occ=4, out_data=7'h11 held; raise out_ready -> 11,22,33,44 emitted in order.
REQ-032 Bubble collapse: out_ready=0, inject 7'h12, idle 2 cycles, inject 7'h34 -> both reach stages 3 and 2 back-to-back; occ=2.
REQ-033 Flush: with 3 digits held, assert flush together with in_valid=1, in_data=7'h7F -> next cycle out_valid=0, occ=0, 7'h7F never appears.
REQ-034 Mid-operation reset: during streaming, pulse rstn low for 1 cycle -> all outputs 0 immediately, no pre-reset digit emitted afterwards.
